// File: rtl/mosby_pkg.sv
// ============================================================================
// Module  : mosby_pkg
// Brief   : Shared codes for the mosby core: branch conditions, status bit
//           positions, ALU ops and operand-mux selects.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mosby_pkg;

    // Branch condition selects carried on branch_op
    localparam logic [2:0] c_op_bpl = 3'd0;
    localparam logic [2:0] c_op_bmi = 3'd1;
    localparam logic [2:0] c_op_bvc = 3'd2;
    localparam logic [2:0] c_op_bvs = 3'd3;
    localparam logic [2:0] c_op_bcc = 3'd4;
    localparam logic [2:0] c_op_bcs = 3'd5;
    localparam logic [2:0] c_op_bne = 3'd6;
    localparam logic [2:0] c_op_beq = 3'd7;

    // Bit positions within the NV-BDIZC status byte
    localparam logic [2:0] c_flag_n = 3'd7;
    localparam logic [2:0] c_flag_v = 3'd6;
    localparam logic [2:0] c_flag_z = 3'd1;
    localparam logic [2:0] c_flag_c = 3'd0;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        OPND_X   = 2'd0,
        OPND_Y   = 2'd1,
        OPND_SP  = 2'd2,
        OPND_IMM = 2'd3
    } opnd_sel_t;

    function automatic logic [15:0] sign_extend8(input logic [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module  : branch_cond
// Brief   : Combinational branch-condition evaluation from branch_op + status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
    import mosby_pkg::*;
(
    input  logic [2:0] branch_op,
    input  logic [7:0] status,
    output logic       taken
);

    logic [2:0] w_flag_idx;

    // Ops come in pairs on one flag; bit 0 gives the flag value that branches.
    always_comb begin
        w_flag_idx = c_flag_n;
        case (branch_op[2:1])
            2'd0:    w_flag_idx = c_flag_n;
            2'd1:    w_flag_idx = c_flag_v;
            2'd2:    w_flag_idx = c_flag_c;
            2'd3:    w_flag_idx = c_flag_z;
            default: w_flag_idx = c_flag_n;
        endcase
    end

    assign taken = (status[w_flag_idx] == branch_op[0]);

endmodule

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// Module  : program_counter
// Brief   : 16-bit fetch address register with absolute jumps and relative
//           conditional branches, including a one-cycle page-cross fix-up.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter
    import mosby_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        increment,
    input  logic        lower_byte,
    input  logic        branch_uncon,
    input  logic        branch_con,
    input  logic [2:0]  branch_op,
    input  logic [7:0]  status,
    input  logic [7:0]  data_in,
    output logic [15:0] pc,
    output logic        flush,
    output logic        stall
);

    localparam logic [0:0] c_st_run = 1'b0;
    localparam logic [0:0] c_st_fix = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [7:0]  r_target_lo;
    logic [7:0]  w_target_lo_nxt;
    logic [7:0]  r_fix_hi;
    logic [7:0]  w_fix_hi_nxt;
    logic        r_flush;
    logic        w_flush_nxt;
    logic        r_stall;
    logic        w_stall_nxt;

    logic        w_cond_true;
    logic [15:0] w_base;
    logic [15:0] w_target;
    logic        w_page_cross;
    logic        w_branch_taken;

    branch_cond u_branch_cond (
        .branch_op (branch_op),
        .status    (status),
        .taken     (w_cond_true)
    );

    assign w_base         = r_pc + {15'd0, increment};
    assign w_target       = w_base + sign_extend8(data_in);
    assign w_page_cross   = (w_target[15:8] != w_base[15:8]);
    assign w_branch_taken = branch_con & ~branch_uncon & w_cond_true;

    // State register and datapath registers
    always_ff @(posedge clk_1) begin
        if (!rst) begin
            r_state     <= c_st_run;
            r_pc        <= RESET_PC;
            r_target_lo <= 8'h00;
            r_fix_hi    <= 8'h00;
            r_flush     <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_target_lo <= w_target_lo_nxt;
            r_fix_hi    <= w_fix_hi_nxt;
            r_flush     <= w_flush_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (w_branch_taken && w_page_cross) begin
                    w_state_nxt = c_st_fix;
                end
            end
            c_st_fix: w_state_nxt = c_st_run;
            default:  w_state_nxt = c_st_run;
        endcase
    end

    // Next values for pc, target latch and the decoder handshakes
    always_comb begin
        w_pc_nxt        = r_pc;
        w_target_lo_nxt = r_target_lo;
        w_fix_hi_nxt    = r_fix_hi;
        w_flush_nxt     = 1'b0;
        w_stall_nxt     = 1'b0;
        case (r_state)
            c_st_run: begin
                if (lower_byte && !branch_uncon) begin
                    w_target_lo_nxt = data_in;
                end
                if (branch_uncon) begin
                    w_pc_nxt    = {data_in, r_target_lo};
                    w_flush_nxt = 1'b1;
                end else if (branch_con) begin
                    if (!w_branch_taken) begin
                        w_pc_nxt = w_base;
                    end else if (!w_page_cross) begin
                        w_pc_nxt    = w_target;
                        w_flush_nxt = 1'b1;
                    end else begin
                        // Low byte lands now; the high byte is patched in FIX.
                        w_pc_nxt     = {w_base[15:8], w_target[7:0]};
                        w_fix_hi_nxt = w_target[15:8];
                        w_stall_nxt  = 1'b1;
                    end
                end else begin
                    w_pc_nxt = w_base;
                end
            end
            c_st_fix: begin
                w_pc_nxt    = {r_fix_hi, r_pc[7:0]};
                w_flush_nxt = 1'b1;
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    assign pc    = r_pc;
    assign flush = r_flush;
    assign stall = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// Module  : tb_program_counter
// Brief   : Self-checking bench for program_counter: directed scenarios plus
//           randomized traffic against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_counter;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk_1;
    logic        rst;
    logic        increment;
    logic        lower_byte;
    logic        branch_uncon;
    logic        branch_con;
    logic [2:0]  branch_op;
    logic [7:0]  status;
    logic [7:0]  data_in;
    logic [15:0] pc;
    logic        flush;
    logic        stall;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_pc;
    int m_target_lo;
    int m_fix_hi;
    bit m_in_fix;
    bit m_flush;
    bit m_stall;

    program_counter #(.RESET_PC(RESET_PC)) dut (
        .clk_1        (clk_1),
        .rst          (rst),
        .increment    (increment),
        .lower_byte   (lower_byte),
        .branch_uncon (branch_uncon),
        .branch_con   (branch_con),
        .branch_op    (branch_op),
        .status       (status),
        .data_in      (data_in),
        .pc           (pc),
        .flush        (flush),
        .stall        (stall)
    );

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    function automatic bit cond_met(input int op, input logic [7:0] s);
        case (op)
            0: return s[7] == 1'b0;  // BPL
            1: return s[7] == 1'b1;  // BMI
            2: return s[6] == 1'b0;  // BVC
            3: return s[6] == 1'b1;  // BVS
            4: return s[0] == 1'b0;  // BCC
            5: return s[0] == 1'b1;  // BCS
            6: return s[1] == 1'b0;  // BNE
            default: return s[1] == 1'b1;  // BEQ
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int base, offset, target, new_lo;
        if (rst == 1'b0) begin
            m_pc = int'(RESET_PC); m_target_lo = 0; m_in_fix = 0;
            m_flush = 0; m_stall = 0;
        end else if (m_in_fix) begin
            m_pc = m_fix_hi * 256 + (m_pc % 256);
            m_in_fix = 0; m_flush = 1; m_stall = 0;
        end else begin
            new_lo = (lower_byte && !branch_uncon) ? int'(data_in) : m_target_lo;
            m_flush = 0; m_stall = 0;
            if (branch_uncon) begin
                m_pc = int'(data_in) * 256 + m_target_lo;
                m_flush = 1;
            end else if (branch_con) begin
                base   = (m_pc + int'(increment)) % 65536;
                offset = (data_in >= 8'd128) ? int'(data_in) - 256 : int'(data_in);
                target = (base + offset + 65536) % 65536;
                if (!cond_met(int'(branch_op), status)) begin
                    m_pc = base;
                end else if (target / 256 == base / 256) begin
                    m_pc = target; m_flush = 1;
                end else begin
                    m_pc = (base / 256) * 256 + (target % 256);
                    m_fix_hi = target / 256; m_in_fix = 1; m_stall = 1;
                end
            end else begin
                m_pc = (m_pc + int'(increment)) % 65536;
            end
            m_target_lo = new_lo;
        end
    endtask

    task automatic tick(input logic r, input logic inc, input logic lb, input logic bu,
                        input logic bc, input logic [2:0] op, input logic [7:0] st,
                        input logic [7:0] d);
        rst = r; increment = inc; lower_byte = lb; branch_uncon = bu;
        branch_con = bc; branch_op = op; status = st; data_in = d;
        model_step();
        @(posedge clk_1);
        #1;
    endtask

    task automatic set_pc(input logic [15:0] value);
        tick(1, 0, 1, 0, 0, 3'd0, 8'h00, value[7:0]);
        tick(1, 0, 0, 1, 0, 3'd0, 8'h00, value[15:8]);
        tick(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        tick(0, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        tick(0, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== RESET_PC || flush !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h flush=%b stall=%b, expected pc=%h flush=0 stall=0",
                     pc, flush, stall, RESET_PC);
        end
        for (int i = 1; i <= 3; i++) begin
            tick(1, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
            checks++;
            if (pc !== 16'(i)) begin
                errors++;
                $display("FAIL count_%0d: pc=%h expected %h", i, pc, 16'(i));
            end
        end
    endtask

    task automatic test_abs_jump();
        tick(1, 0, 1, 0, 0, 3'd0, 8'h00, 8'h34);
        tick(1, 0, 0, 1, 0, 3'd0, 8'h00, 8'h12);
        checks++;
        if (pc !== 16'h1234 || flush !== 1'b1) begin
            errors++;
            $display("FAIL jump: pc=%h flush=%b, expected pc=1234 flush=1", pc, flush);
        end
        tick(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== 16'h1234 || flush !== 1'b0) begin
            errors++;
            $display("FAIL jump_flush_width: pc=%h flush=%b, expected pc=1234 flush=0", pc, flush);
        end
        // lower_byte alongside branch_uncon must not disturb target_lo
        tick(1, 0, 1, 0, 0, 3'd0, 8'h00, 8'h56);
        tick(1, 0, 1, 1, 1, 3'd7, 8'hFF, 8'h12);
        checks++;
        if (pc !== 16'h1256 || flush !== 1'b1) begin
            errors++;
            $display("FAIL jump_lb_same: pc=%h flush=%b, expected pc=1256 flush=1", pc, flush);
        end
        tick(1, 0, 0, 1, 0, 3'd0, 8'h00, 8'hAB);
        checks++;
        if (pc !== 16'hAB56) begin
            errors++;
            $display("FAIL target_lo_kept: pc=%h expected AB56", pc);
        end
    endtask

    task automatic test_same_page();
        set_pc(16'h0200);
        tick(1, 1, 0, 0, 1, 3'd7, 8'h02, 8'h05);
        checks++;
        if (pc !== 16'h0206 || flush !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL beq_taken: pc=%h flush=%b stall=%b, expected 0206/1/0", pc, flush, stall);
        end
        set_pc(16'h0200);
        tick(1, 1, 0, 0, 1, 3'd7, 8'h00, 8'h05);
        checks++;
        if (pc !== 16'h0201 || flush !== 1'b0) begin
            errors++;
            $display("FAIL beq_not_taken: pc=%h flush=%b, expected 0201/0", pc, flush);
        end
    endtask

    task automatic test_page_cross();
        set_pc(16'h02F0);
        tick(1, 1, 0, 0, 1, 3'd4, 8'h00, 8'h20);
        checks++;
        if (pc !== 16'h0211 || stall !== 1'b1 || flush !== 1'b0) begin
            errors++;
            $display("FAIL cross_c1: pc=%h stall=%b flush=%b, expected 0211/1/0", pc, stall, flush);
        end
        // Everything toggled during FIX must be ignored
        tick(1, 1, 1, 1, 1, 3'd5, 8'hFF, 8'h99);
        checks++;
        if (pc !== 16'h0311 || flush !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL cross_c2: pc=%h flush=%b stall=%b, expected 0311/1/0", pc, flush, stall);
        end
        tick(1, 0, 0, 1, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== 16'h00F0) begin
            errors++;
            $display("FAIL fix_ignores_lb: pc=%h expected 00F0", pc);
        end
    endtask

    task automatic test_wrap();
        set_pc(16'hFFFF);
        tick(1, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_inc: pc=%h expected 0000", pc);
        end
        set_pc(16'h0004);
        tick(1, 1, 0, 0, 1, 3'd0, 8'h00, 8'hF0);
        checks++;
        if (pc !== 16'h00F5 || stall !== 1'b1) begin
            errors++;
            $display("FAIL wrap_neg_c1: pc=%h stall=%b, expected 00F5/1", pc, stall);
        end
        tick(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== 16'hFFF5 || flush !== 1'b1) begin
            errors++;
            $display("FAIL wrap_neg_c2: pc=%h flush=%b, expected FFF5/1", pc, flush);
        end
        set_pc(16'hFFEF);
        tick(1, 1, 0, 0, 1, 3'd2, 8'h00, 8'h20);
        tick(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== 16'h0010 || flush !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pos: pc=%h flush=%b, expected 0010/1", pc, flush);
        end
    endtask

    task automatic test_reset_mid_fix();
        set_pc(16'h02F0);
        tick(1, 1, 0, 0, 1, 3'd4, 8'h00, 8'h20);
        tick(0, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== RESET_PC || stall !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_fix: pc=%h stall=%b flush=%b, expected %h/0/0",
                     pc, stall, flush, RESET_PC);
        end
        tick(1, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        checks++;
        if (pc !== RESET_PC + 16'd1 || flush !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_fix_run: pc=%h flush=%b stall=%b, expected %h/0/0",
                     pc, flush, stall, RESET_PC + 16'd1);
        end
    endtask

    task automatic test_random();
        logic r, inc, lb, bu, bc;
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 39) != 0);
            inc = ($urandom_range(0, 9) < 7);
            lb  = ($urandom_range(0, 9) < 3);
            bu  = ($urandom_range(0, 9) < 1);
            bc  = ($urandom_range(0, 9) < 4);
            tick(r, inc, lb, bu, bc, 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            checks++;
            if (pc !== 16'(m_pc) || flush !== m_flush || stall !== m_stall) begin
                errors++;
                $display("FAIL random_%0d: pc=%h flush=%b stall=%b, expected %h/%b/%b",
                         n, pc, flush, stall, 16'(m_pc), m_flush, m_stall);
            end
        end
    endtask

    initial begin
        rst = 1'b0; increment = 1'b0; lower_byte = 1'b0; branch_uncon = 1'b0;
        branch_con = 1'b0; branch_op = 3'd0; status = 8'h00; data_in = 8'h00;
        m_pc = 0; m_target_lo = 0; m_fix_hi = 0; m_in_fix = 0; m_flush = 0; m_stall = 0;
        @(posedge clk_1);
        #1;
        test_reset();
        test_abs_jump();
        test_same_page();
        test_page_cross();
        test_wrap();
        test_reset_mid_fix();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
